// File: rtl/fifo_word_packer.sv
// Drains a first-word-fall-through byte FIFO and packs BPW consecutive bytes into one word on a valid/ready port.
// Define PACKER_FLUSH_EN to flush a partial word after TIMEOUT_CYC idle cycles.
module fifo_word_packer #(
    parameter int BPW         = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               rd_clk,
    input  logic               reset,
    input  logic               fifo_empty,
    input  logic [7:0]         fifo_data,
    output logic               fifo_rd,
    output logic [8*BPW-1:0]   word_out,
    output logic               word_valid,
    input  logic               word_ready,
    output logic [3:0]         word_bytes
);

    localparam int CW = $clog2(BPW);
    localparam logic [CW-1:0] LAST_LANE = CW'(BPW - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [8*BPW-1:0]   word_q, word_d;

`ifdef PACKER_FLUSH_EN
    logic [7:0]         idle_q, idle_d;
    logic [3:0]         bytes_q, bytes_d;
`else
    logic [7:0]         timeout_unused;
    assign timeout_unused = 8'(TIMEOUT_CYC);
`endif

    // NOTE: every variable gets its hold value before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
`ifdef PACKER_FLUSH_EN
        idle_d  = idle_q;
        bytes_d = bytes_q;
`endif
        // The FIFO has no underflow guard, so the pop must never fire while it is empty.
        fifo_rd = (state_q == FILL) && !fifo_empty && !reset;

        case (state_q)
            FILL: begin
                if (fifo_rd) begin
                    for (int i = 0; i < BPW; i++) begin
                        if (cnt_q == CW'(i)) word_d[8*i +: 8] = fifo_data;
                    end
`ifdef PACKER_FLUSH_EN
                    idle_d = '0;
`endif
                    if (cnt_q == LAST_LANE) begin
                        cnt_d   = '0;
                        state_d = HOLD;
`ifdef PACKER_FLUSH_EN
                        bytes_d = 4'(BPW);
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef PACKER_FLUSH_EN
                else if (cnt_q != '0) begin
                    // The idle cycle that brings the count to TIMEOUT_CYC is the one that flushes.
                    if (idle_q == 8'(TIMEOUT_CYC - 1)) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        bytes_d = 4'(cnt_q);
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 8'd1;
                    end
                end
`endif
            end

            HOLD: begin
                if (word_ready) begin
                    state_d = FILL;
                    word_d  = '0;
                end
            end

            default: state_d = FILL;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            word_q  <= '0;
`ifdef PACKER_FLUSH_EN
            idle_q  <= '0;
            bytes_q <= 4'(BPW);
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
`ifdef PACKER_FLUSH_EN
            idle_q  <= idle_d;
            bytes_q <= bytes_d;
`endif
        end
    end

    assign word_out   = word_q;
    assign word_valid = (state_q == HOLD);
`ifdef PACKER_FLUSH_EN
    assign word_bytes = bytes_q;
`else
    assign word_bytes = 4'(BPW);
`endif

endmodule
